// File: rtl/qslave_sync_if.sv
// QBUS slave strobes plus the internal I/O-bus signals of qslave_sync.
// Defining QSLAVE_BYTE_WRITE_EN adds the iWBYTE byte-lane enables.
interface qslave_sync_if;
  // QBUS side (receivers / drivers)
  logic        RSYNC;
  logic        RDIN;
  logic        RDOUT;
  logic        RINIT;
  logic        ZBS7;
  logic        ZWTBT;
  logic        DALtx;
  logic        DALst;
  logic        TRPLY;
  // Internal I/O bus
  logic [12:0] iADDR;
  logic        iBS7;
  logic        iREAD_MATCH;
  logic        iWRITE_MATCH;
  logic [15:0] iRDATA;
  logic [15:0] iWDATA;
  logic        iWRITE;
`ifdef QSLAVE_BYTE_WRITE_EN
  logic [1:0]  iWBYTE;
`endif

  modport slave (
    input  RSYNC, RDIN, RDOUT, RINIT, ZBS7, ZWTBT,
    input  iREAD_MATCH, iWRITE_MATCH, iRDATA,
`ifdef QSLAVE_BYTE_WRITE_EN
    output iWBYTE,
`endif
    output DALtx, DALst, TRPLY, iADDR, iBS7, iWDATA, iWRITE
  );

  modport master (
    output RSYNC, RDIN, RDOUT, RINIT, ZBS7, ZWTBT,
    output iREAD_MATCH, iWRITE_MATCH, iRDATA,
`ifdef QSLAVE_BYTE_WRITE_EN
    input  iWBYTE,
`endif
    input  DALtx, DALst, TRPLY, iADDR, iBS7, iWDATA, iWRITE
  );
endinterface

// File: rtl/qslave_sync.sv
// QBUS slave cycle sequencer (DATI/DATO/DATIO) between the qdrv pins and the internal I/O bus.
// Define QSLAVE_BYTE_WRITE_EN to add iWBYTE byte-lane enables for DATOB.
module qslave_sync #(
  parameter int unsigned SYNC_STAGES = 2,  // must be >= 2
  parameter int unsigned RPLY_DELAY  = 2   // must be >= 1
) (
  input  logic         qclk,
  input  logic         reset_L,
  inout  wire   [21:0] ZDAL,
  qslave_sync_if.slave bus
);

  localparam int unsigned CntW = (RPLY_DELAY > 1) ? $clog2(RPLY_DELAY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RPLY_DELAY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRdata,
    StRreply,
    StRdone,
    StWdata,
    StWreply,
    StSkip
  } state_e;

  typedef struct packed {
    logic init;
    logic wtbt;
    logic bs7;
    logic dout;
    logic din;
    logic sync;
  } pins_t;

  pins_t                        pins_in;
  pins_t                        pins_s;
  pins_t [SYNC_STAGES-1:0]      pins_q;
  logic  [SYNC_STAGES-1:0][15:0] dal_q;
  logic  [15:0]                 p_dal;

  state_e          state_q;
  logic            sync_prev_q;
  logic            dal_tx_q;
  logic            dal_st_q;
  logic            trply_q;
  logic            iwrite_q;
  logic            ibs7_q;
  logic [12:0]     iaddr_q;
  logic [15:0]     iwdata_q;
  logic [CntW-1:0] cnt_q;
`ifdef QSLAVE_BYTE_WRITE_EN
  logic [1:0]      wbyte_q;
`endif

  assign pins_in = '{init: bus.RINIT, wtbt: bus.ZWTBT, bs7: bus.ZBS7,
                     dout: bus.RDOUT, din: bus.RDIN, sync: bus.RSYNC};

  // Strobes and DAL/BS7/WTBT samples share one pipe depth so pDAL lines up with sSYNC.
  always_ff @(posedge qclk or negedge reset_L) begin
    if (!reset_L) begin
      pins_q <= '0;
      dal_q  <= '0;
    end else begin
      pins_q <= {pins_q[SYNC_STAGES-2:0], pins_in};
      dal_q  <= {dal_q[SYNC_STAGES-2:0], ZDAL[15:0]};
    end
  end

  assign pins_s = pins_q[SYNC_STAGES-1];
  assign p_dal  = dal_q[SYNC_STAGES-1];

  logic unused_zdal_hi;
  assign unused_zdal_hi = ^ZDAL[21:16];
`ifndef QSLAVE_BYTE_WRITE_EN
  logic unused_wtbt;
  assign unused_wtbt = pins_s.wtbt;
`endif

  always_ff @(posedge qclk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StIdle;
      sync_prev_q <= 1'b0;
      dal_tx_q    <= 1'b0;
      dal_st_q    <= 1'b0;
      trply_q     <= 1'b0;
      iwrite_q    <= 1'b0;
      ibs7_q      <= 1'b0;
      iaddr_q     <= '0;
      iwdata_q    <= '0;
      cnt_q       <= '0;
`ifdef QSLAVE_BYTE_WRITE_EN
      wbyte_q     <= 2'b11;
`endif
    end else begin
      sync_prev_q <= pins_s.sync;
      dal_st_q    <= 1'b0;
      iwrite_q    <= 1'b0;
      if (pins_s.init) begin
        state_q  <= StIdle;
        dal_tx_q <= 1'b0;
        trply_q  <= 1'b0;
        ibs7_q   <= 1'b0;
        iaddr_q  <= '0;
        iwdata_q <= '0;
        cnt_q    <= '0;
`ifdef QSLAVE_BYTE_WRITE_EN
        wbyte_q  <= 2'b11;
`endif
      end else if (state_q != StIdle && !pins_s.sync) begin
        // Master dropped SYNC: abandon the cycle wherever it is.
        state_q  <= StIdle;
        dal_tx_q <= 1'b0;
        trply_q  <= 1'b0;
        ibs7_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pins_s.sync && !sync_prev_q) begin
              iaddr_q <= p_dal[12:0];
              ibs7_q  <= pins_s.bs7;
              state_q <= pins_s.bs7 ? StAddr : StSkip;
            end
          end
          StAddr: begin
            // DIN wins over DOUT; a pending DOUT is taken up again from StRdone.
            if (pins_s.din) begin
              if (bus.iREAD_MATCH) begin
                state_q  <= StRdata;
                dal_tx_q <= 1'b1;
                dal_st_q <= 1'b1;
                cnt_q    <= '0;
              end else begin
                state_q <= StSkip;
              end
            end else if (pins_s.dout) begin
              state_q <= StWdata;
            end
          end
          StRdata: begin
            if (cnt_q == CntLast) begin
              trply_q <= 1'b1;
              state_q <= StRreply;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StRreply: begin
            if (!pins_s.din) begin
              trply_q  <= 1'b0;
              dal_tx_q <= 1'b0;
              state_q  <= StRdone;
            end
          end
          StRdone: begin
            if (pins_s.dout) begin
              state_q <= StWdata;
            end
          end
          StWdata: begin
            if (bus.iWRITE_MATCH) begin
              iwdata_q <= p_dal;
              iwrite_q <= 1'b1;
              trply_q  <= 1'b1;
              state_q  <= StWreply;
`ifdef QSLAVE_BYTE_WRITE_EN
              wbyte_q  <= pins_s.wtbt ? (iaddr_q[0] ? 2'b10 : 2'b01) : 2'b11;
`endif
            end else begin
              state_q <= StSkip;
            end
          end
          StWreply: begin
            if (!pins_s.dout) begin
              trply_q <= 1'b0;
              state_q <= StRdone;
            end
          end
          StSkip: begin
            state_q <= StSkip;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // DALtx rises only on entry to StRdata, after the master has released DAL for DIN.
  assign ZDAL = dal_tx_q ? {6'b0, bus.iRDATA} : 'z;

  assign bus.DALtx  = dal_tx_q;
  assign bus.DALst  = dal_st_q;
  assign bus.TRPLY  = trply_q;
  assign bus.iWRITE = iwrite_q;
  assign bus.iBS7   = ibs7_q;
  assign bus.iADDR  = iaddr_q;
  assign bus.iWDATA = iwdata_q;
`ifdef QSLAVE_BYTE_WRITE_EN
  assign bus.iWBYTE = wbyte_q;
`endif

endmodule

// File: tb/tb_qslave_sync.sv
// Directed bench for qslave_sync: a stand-in register block answers the I/O bus and a
// bus-master task set runs DATI/DATO/DATIO cycles from a vector table, plus corner cases.
`timescale 1ns/1ps
module tb_qslave_sync;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned RplyDelay  = 2;
  localparam int RdLat      = int'(SyncStages) + 1 + int'(RplyDelay);  // RDIN set -> TRPLY
  localparam int WrLat      = int'(SyncStages) + 2;                   // RDOUT set -> TRPLY
  localparam int NoRplyWait = 20;                                     // 1 us at 20 MHz
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  typedef struct {
    logic [21:0] addr;
    logic        bs7;
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    logic        wtbt;
    logic        exp_rply;
    logic [15:0] exp_rdata;
    int          exp_writes;
    logic [1:0]  exp_wbyte;
  } vec_t;

  logic        qclk = 1'b0;
  logic        reset_L = 1'b0;
  logic        dal_en = 1'b0;
  logic [21:0] dal_drv = '0;
  wire  [21:0] zdal;

  always #25 qclk = ~qclk;

  assign zdal = dal_en ? dal_drv : 'z;

  qslave_sync_if bus ();

  qslave_sync #(
    .SYNC_STAGES(SyncStages),
    .RPLY_DELAY (RplyDelay)
  ) dut (
    .qclk   (qclk),
    .reset_L(reset_L),
    .ZDAL   (zdal),
    .bus    (bus)
  );

  // Stand-in register block: 17570 read-only switch register, 17440/17442/17560 read/write.
  logic [15:0] reg440, reg442, reg560;
  logic [1:0]  wb;
`ifdef QSLAVE_BYTE_WRITE_EN
  assign wb = bus.iWBYTE;
`else
  assign wb = 2'b11;
`endif

  always_comb begin
    bus.iREAD_MATCH  = 1'b0;
    bus.iWRITE_MATCH = 1'b0;
    bus.iRDATA       = '0;
    if (bus.iBS7) begin
      case (bus.iADDR)
        13'o17570: begin bus.iREAD_MATCH = 1'b1; bus.iRDATA = 16'o177777; end
        13'o17440: begin bus.iREAD_MATCH = 1'b1; bus.iWRITE_MATCH = 1'b1; bus.iRDATA = reg440; end
        13'o17441: begin bus.iREAD_MATCH = 1'b1; bus.iWRITE_MATCH = 1'b1; bus.iRDATA = reg440; end
        13'o17442: begin bus.iREAD_MATCH = 1'b1; bus.iWRITE_MATCH = 1'b1; bus.iRDATA = reg442; end
        13'o17560: begin bus.iREAD_MATCH = 1'b1; bus.iWRITE_MATCH = 1'b1; bus.iRDATA = reg560; end
        default: ;
      endcase
    end
  end

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] lanes);
    return {lanes[1] ? nw[15:8] : old[15:8], lanes[0] ? nw[7:0] : old[7:0]};
  endfunction

  always @(posedge qclk or negedge reset_L) begin
    if (!reset_L) begin
      reg440 <= '0;
      reg442 <= '0;
      reg560 <= '0;
    end else if (bus.iWRITE) begin
      case (bus.iADDR)
        13'o17440, 13'o17441: reg440 <= merge(reg440, bus.iWDATA, wb);
        13'o17442:            reg442 <= merge(reg442, bus.iWDATA, wb);
        13'o17560:            reg560 <= merge(reg560, bus.iWDATA, wb);
        default: ;
      endcase
    end
  end

  // Event monitors: free-running counts, differenced around each transaction.
  int   n_iwrite = 0;
  int   n_dalst  = 0;
  int   n_rply   = 0;
  logic trply_prev = 1'b0;
  logic [1:0] last_wbyte = 2'b11;
  always @(posedge qclk) begin
    trply_prev <= bus.TRPLY;
    if (bus.iWRITE) begin
      n_iwrite   <= n_iwrite + 1;
      last_wbyte <= wb;
    end
    if (bus.DALst) n_dalst <= n_dalst + 1;
    if (bus.TRPLY && !trply_prev) n_rply <= n_rply + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o, expected %0o", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge qclk);
      #1;
    end
  endtask

  task automatic wait_trply(input logic want, input int limit, output int cyc, output logic hit);
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < limit) begin
      tick(1);
      cyc++;
      hit = (bus.TRPLY == want);
    end
  endtask

  task automatic addr_phase(input logic [21:0] addr, input logic bs7);
    dal_drv = addr;
    dal_en  = 1'b1;
    bus.ZBS7 = bs7;
    tick(1);
    bus.RSYNC = 1'b1;
    tick(int'(SyncStages) + 2);
    dal_en   = 1'b0;
    bus.ZBS7 = 1'b0;
    tick(1);
  endtask

  task automatic read_phase(output logic rply, output int lat, output logic [21:0] data,
                            output logic fell);
    int c;
    bus.RDIN = 1'b1;
    wait_trply(1'b1, NoRplyWait, lat, rply);
    data = zdal;
    bus.RDIN = 1'b0;
    if (rply) wait_trply(1'b0, 10, c, fell);
    else fell = 1'b1;
  endtask

  task automatic write_phase(input logic [15:0] data, input logic wtbt, output logic rply,
                             output int lat, output logic fell);
    int c;
    dal_drv   = {6'b0, data};
    dal_en    = 1'b1;
    bus.ZWTBT = wtbt;
    bus.RDOUT = 1'b1;
    wait_trply(1'b1, NoRplyWait, lat, rply);
    bus.RDOUT = 1'b0;
    if (rply) wait_trply(1'b0, 10, c, fell);
    else fell = 1'b1;
    dal_en    = 1'b0;
    bus.ZWTBT = 1'b0;
  endtask

  task automatic end_cycle();
    bus.RSYNC = 1'b0;
    bus.RDIN  = 1'b0;
    bus.RDOUT = 1'b0;
    bus.ZWTBT = 1'b0;
    dal_en    = 1'b0;
    tick(int'(SyncStages) + 3);
  endtask

  function automatic vec_t mk(input logic [21:0] a, input logic b7, input logic rd,
                              input logic wr, input logic [15:0] wd, input logic wt,
                              input logic er, input logic [15:0] erd, input int ew,
                              input logic [1:0] ewb);
    vec_t v;
    v.addr = a; v.bs7 = b7; v.rd = rd; v.wr = wr; v.wdata = wd; v.wtbt = wt;
    v.exp_rply = er; v.exp_rdata = erd; v.exp_writes = ew; v.exp_wbyte = ewb;
    return v;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic        rply, fell;
    int          lat, w0, s0, r0;
    logic [21:0] rdat;
    string       id;

    //                addr          bs7 rd wr wdata       wtbt rply rdata      wr  wbyte
    vecs.push_back(mk(22'o17777570, T, T, F, 16'o000000, F, T, 16'o177777, 0, 2'b11));
    vecs.push_back(mk(22'o17777440, T, F, T, 16'o054321, F, T, 16'o000000, 1, 2'b11));
    vecs.push_back(mk(22'o17777440, T, T, F, 16'o000000, F, T, 16'o054321, 0, 2'b11));
    vecs.push_back(mk(22'o17777400, T, T, F, 16'o000000, F, F, 16'o000000, 0, 2'b11));
    vecs.push_back(mk(22'o17777440, F, T, F, 16'o000000, F, F, 16'o000000, 0, 2'b11));
    vecs.push_back(mk(22'o17777440, F, F, T, 16'o000000, F, F, 16'o000000, 0, 2'b11));
    vecs.push_back(mk(22'o17777440, T, T, F, 16'o000000, F, T, 16'o054321, 0, 2'b11));
    vecs.push_back(mk(22'o17777560, T, F, T, 16'o123456, F, T, 16'o000000, 1, 2'b11));
    vecs.push_back(mk(22'o17777560, T, T, T, 16'o054545, F, T, 16'o123456, 1, 2'b11));
    vecs.push_back(mk(22'o17777560, T, T, F, 16'o000000, F, T, 16'o054545, 0, 2'b11));
    vecs.push_back(mk(22'o17777570, T, F, T, 16'o000000, F, F, 16'o000000, 0, 2'b11));
    vecs.push_back(mk(22'o17777442, T, F, T, 16'o000777, F, T, 16'o000000, 1, 2'b11));
    vecs.push_back(mk(22'o17777442, T, T, F, 16'o000000, F, T, 16'o000777, 0, 2'b11));
`ifdef QSLAVE_BYTE_WRITE_EN
    // DATOB: odd byte to 17441 lands in the high lane of 17440, even byte in the low lane.
    vecs.push_back(mk(22'o17777441, T, F, T, 16'hA500,   T, T, 16'o000000, 1, 2'b10));
    vecs.push_back(mk(22'o17777440, T, T, F, 16'o000000, F, T, 16'o122721, 0, 2'b11));
    vecs.push_back(mk(22'o17777442, T, F, T, 16'h00AB,   T, T, 16'o000000, 1, 2'b01));
    vecs.push_back(mk(22'o17777442, T, T, F, 16'o000000, F, T, 16'h01AB,   0, 2'b11));
`endif

    bus.RSYNC = 1'b0; bus.RDIN = 1'b0; bus.RDOUT = 1'b0; bus.RINIT = 1'b0;
    bus.ZBS7  = 1'b0; bus.ZWTBT = 1'b0;
    reset_L = 1'b0;
    tick(3);
    check("reset TRPLY",  32'(bus.TRPLY),  32'(0));
    check("reset DALtx",  32'(bus.DALtx),  32'(0));
    check("reset DALst",  32'(bus.DALst),  32'(0));
    check("reset iWRITE", 32'(bus.iWRITE), 32'(0));
    check("reset iBS7",   32'(bus.iBS7),   32'(0));
    check("reset iADDR",  32'(bus.iADDR),  32'(0));
    check("reset iWDATA", 32'(bus.iWDATA), 32'(0));
`ifdef QSLAVE_BYTE_WRITE_EN
    check("reset iWBYTE", 32'(bus.iWBYTE), 32'(2'b11));
`endif
    reset_L = 1'b1;
    tick(3);

    foreach (vecs[i]) begin
      v  = vecs[i];
      id = $sformatf("v%0d", i);
      w0 = n_iwrite; s0 = n_dalst; r0 = n_rply;
      addr_phase(v.addr, v.bs7);
      check({id, " iADDR"}, 32'(bus.iADDR), 32'(v.addr[12:0]));
      check({id, " iBS7"},  32'(bus.iBS7),  32'(v.bs7));
      if (v.rd) begin
        read_phase(rply, lat, rdat, fell);
        check({id, " read TRPLY"}, 32'(rply), 32'(v.exp_rply));
        if (v.exp_rply) begin
          check({id, " read latency"}, 32'(lat), 32'(RdLat));
          check({id, " read data"}, 32'(rdat), 32'({6'b0, v.exp_rdata}));
          check({id, " read TRPLY drop"}, 32'(fell), 32'(1));
        end
      end
      if (v.wr) begin
        write_phase(v.wdata, v.wtbt, rply, lat, fell);
        check({id, " write TRPLY"}, 32'(rply), 32'(v.exp_rply));
        if (v.exp_rply) begin
          check({id, " write latency"}, 32'(lat), 32'(WrLat));
          check({id, " write TRPLY drop"}, 32'(fell), 32'(1));
          check({id, " iWDATA"}, 32'(bus.iWDATA), 32'(v.wdata));
`ifdef QSLAVE_BYTE_WRITE_EN
          check({id, " iWBYTE"}, 32'(last_wbyte), 32'(v.exp_wbyte));
`endif
        end
      end
      end_cycle();
      check({id, " iWRITE pulses"}, 32'(n_iwrite - w0), 32'(v.exp_writes));
      check({id, " DALst pulses"}, 32'(n_dalst - s0), 32'((v.rd && v.exp_rply) ? 1 : 0));
      check({id, " TRPLY pulses"}, 32'(n_rply - r0),
            32'(v.exp_rply ? (int'(v.rd) + int'(v.wr)) : 0));
      check({id, " idle iBS7"},  32'(bus.iBS7),  32'(0));
      check({id, " idle DALtx"}, 32'(bus.DALtx), 32'(0));
    end

    // SYNC dropped while TRPLY is up: cycle aborts, TRPLY and DALtx forced low.
    addr_phase(22'o17777570, T);
    bus.RDIN = 1'b1;
    wait_trply(1'b1, NoRplyWait, lat, rply);
    check("abort TRPLY up", 32'(rply), 32'(1));
    bus.RSYNC = 1'b0;
    tick(int'(SyncStages) + 1);
    check("abort TRPLY", 32'(bus.TRPLY), 32'(0));
    check("abort DALtx", 32'(bus.DALtx), 32'(0));
    end_cycle();

    // RINIT mid-cycle: back to IDLE with reset outputs; the following DOUT gets no reply.
    w0 = n_iwrite; r0 = n_rply;
    addr_phase(22'o17777440, T);
    bus.RINIT = 1'b1;
    tick(3);
    bus.RINIT = 1'b0;
    tick(int'(SyncStages) + 1);
    check("rinit iADDR", 32'(bus.iADDR), 32'(0));
    check("rinit iBS7",  32'(bus.iBS7),  32'(0));
    write_phase(16'o111111, F, rply, lat, fell);
    check("rinit TRPLY", 32'(rply), 32'(0));
    end_cycle();
    check("rinit iWRITE pulses", 32'(n_iwrite - w0), 32'(0));
    check("rinit TRPLY pulses",  32'(n_rply - r0),   32'(0));

    // Asynchronous reset in the middle of RREPLY.
    addr_phase(22'o17777570, T);
    bus.RDIN = 1'b1;
    wait_trply(1'b1, NoRplyWait, lat, rply);
    check("areset TRPLY up", 32'(rply), 32'(1));
    #10;
    reset_L = 1'b0;
    #1;
    check("areset TRPLY", 32'(bus.TRPLY), 32'(0));
    check("areset DALtx", 32'(bus.DALtx), 32'(0));
    check("areset iBS7",  32'(bus.iBS7),  32'(0));
    bus.RDIN  = 1'b0;
    bus.RSYNC = 1'b0;
    dal_drv = 22'h2AAAA;
    dal_en  = 1'b1;
    #1;
    check("areset ZDAL released", 32'(zdal), 32'(22'h2AAAA));
    dal_en = 1'b0;
    tick(2);
    reset_L = 1'b1;
    tick(int'(SyncStages) + 2);
    check("areset iADDR", 32'(bus.iADDR), 32'(0));
    addr_phase(22'o17777570, T);
    read_phase(rply, lat, rdat, fell);
    check("post-reset read TRPLY", 32'(rply), 32'(1));
    check("post-reset read data",  32'(rdat), 32'({6'b0, 16'o177777}));
    end_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
